oldland_prefetch: RTL
=====================

OLDLAND_PREFETCH -- requirements
Module: oldland_prefetch

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port i_access, input, 1, fetch request from pipeline; held high until i_ack.
REQ-004 SHALL have port i_addr, input, 30, word address of requested instruction.
REQ-005 SHALL have port i_data, output, 32, instruction word; valid only while i_ack high.
REQ-006 SHALL have port i_ack, output, 1, single-cycle completion pulse.
REQ-007 SHALL have port i_error, output, 1, bus error flag for the fetch; valid only while i_ack high.
REQ-008 SHALL have port i_inval, input, 1, flush all buffered words.
REQ-009 SHALL have port m_access, output, 1, memory-side request.
REQ-010 SHALL have port m_addr, output, 30, memory-side word address.
REQ-011 SHALL have port m_data, input, 32, memory read data, sampled when m_ack high.
REQ-012 SHALL have port m_ack, input, 1, memory completion.
REQ-013 SHALL have port m_error, input, 1, memory error completion; mutually exclusive with m_ack.

Function
REQ-014 SHALL hold a 4-entry FIFO of {data[31:0], err}, occupancy count 0..4, and head_addr (word address of oldest entry).
REQ-015 SHALL compute next-fetch address = head_addr + count + (1 if a kept request is in flight), modulo 2^30 (0x3FFFFFFF wraps to 0).
REQ-016 SHALL run memory FSM states M_IDLE, M_FETCH (in flight, result kept), M_DISCARD (in flight, result dropped).
REQ-017 M_IDLE -> M_FETCH SHALL occur when count + pending < 4, no buffered entry has err set, and i_access is high or count > 0; m_addr = next-fetch address.
REQ-018 While in M_FETCH or M_DISCARD, m_access SHALL stay high and m_addr stable until m_ack or m_error; at most one request outstanding.
REQ-019 On m_ack/m_error in M_FETCH, SHALL push {m_data, m_error} at tail and return to M_IDLE; in M_DISCARD SHALL drop the result and return to M_IDLE.
REQ-020 Lookup SHALL occur in any cycle with i_access high and i_ack low.
REQ-021 Hit (count > 0 and i_addr == head_addr): next cycle i_ack=1, i_data/i_error = head entry; pop; head_addr += 1.
REQ-022 Miss (count == 0 with no kept request for i_addr, or i_addr != head_addr): count cleared, head_addr = i_addr; an in-flight M_FETCH becomes M_DISCARD; new fetch of i_addr issues per REQ-017.
REQ-023 Empty buffer with kept request already in flight for i_addr: SHALL wait, no flush; response push then hit next cycle.
REQ-024 Push and pop in the same cycle SHALL leave count unchanged.
REQ-025 Hit latency SHALL be 1 cycle; miss latency SHALL be memory latency + 2 cycles from lookup.
REQ-026 i_inval SHALL clear count, convert M_FETCH to M_DISCARD, and suppress any hit in that cycle; pending i_access is re-evaluated next cycle as miss.
REQ-027 Error entries SHALL be delivered in order with i_error=1; prefetch SHALL stop past an error entry until a flush or the error entry is popped.

Reset
REQ-028 On rst_n low: count=0, head_addr=0, FSM=M_IDLE, m_access=0, m_addr=0, i_ack=0, i_error=0, i_data=0.
REQ-029 Reset mid-transfer SHALL abandon the outstanding memory request immediately; no late m_ack after release SHALL be pushed.

Verification
REQ-030 Cold miss: i_access, i_addr=0x100, memory acks 3 cycles with 0xDEADBEEF -> m_addr=0x100, i_ack with i_data=0xDEADBEEF 5 cycles after lookup; prefetch of 0x101 starts.
REQ-031 Sequential stream: fetch 0x100..0x107, 1-cycle memory -> after first, every fetch hits with 1-cycle latency; count never exceeds 4.
REQ-032 Branch: buffer holds 0x101..0x104, request 0x200 while 0x105 in flight -> 0x105 result discarded, m_addr=0x200 next, i_data from 0x200 response.
REQ-033 Error: m_error on 0x102 -> i_ack with i_error=1 for 0x102, no m_access for 0x103 until redirect.
REQ-034 Wrap: i_addr=0x3FFFFFFE -> prefetches 0x3FFFFFFF then 0x00000000.
REQ-035 i_inval concurrent with hit on 0x100 -> no i_ack that cycle, count=0, 0x100 refetched from memory.

Source files
------------

// File: rtl/oldland_prefetch.sv
// Instruction prefetch buffer: a 4-deep FIFO of sequential words ahead of the fetch address,
// with a single outstanding memory read that is kept, or dropped when a redirect makes it stale.
module oldland_prefetch (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_access,
    input  logic [29:0] i_addr,
    output logic [31:0] i_data,
    output logic        i_ack,
    output logic        i_error,
    input  logic        i_inval,
    output logic        m_access,
    output logic [29:0] m_addr,
    input  logic [31:0] m_data,
    input  logic        m_ack,
    input  logic        m_error
);

    typedef enum logic [1:0] {
        MIdle,
        MFetch,
        MDiscard
    } mstate_e;

    mstate_e     mstate_q, mstate_d;
    logic [29:0] m_addr_q, m_addr_d;

    logic [31:0] data_q [4];
    logic [3:0]  err_q;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic [29:0] head_q, head_d;

    logic        i_ack_q, i_ack_d;
    logic        i_error_q, i_error_d;
    logic [31:0] i_data_q, i_data_d;

    logic        lookup, pending, m_done;
    logic        head_hit, kept_wait;
    logic        hit, miss, flush, push;
    logic        err_any;
    logic [1:0]  wr_idx;
    logic [2:0]  count_e;
    logic [29:0] head_e;
    logic        err_e;
    logic [29:0] next_fetch;
    logic        issue;

    assign lookup  = i_access & ~i_ack_q;
    assign pending = (mstate_q == MFetch);
    assign m_done  = m_ack | m_error;

    assign head_hit = (count_q != 3'd0) && (i_addr == head_q);
    // The word for i_addr is already on its way into an empty buffer: wait rather than flush.
    assign kept_wait = (count_q == 3'd0) && pending && (m_addr_q == i_addr);

    assign hit   = lookup & ~i_inval & head_hit;
    assign miss  = lookup & ~i_inval & ~head_hit & ~kept_wait;
    assign flush = i_inval | miss;
    assign push  = pending & m_done & ~flush;

    assign wr_idx = rd_ptr_q + count_q[1:0];

    always_comb begin
        err_any = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if ((3'(i) < count_q) && err_q[rd_ptr_q + 2'(i)]) begin
                err_any = 1'b1;
            end
        end
    end

    // Issue decisions look at the buffer as it will stand after this cycle's flush.
    always_comb begin
        count_e    = flush ? 3'd0 : count_q;
        head_e     = miss ? i_addr : head_q;
        err_e      = flush ? 1'b0 : err_any;
        next_fetch = head_e + 30'(count_e) + 30'(pending);
        issue      = (mstate_q == MIdle) & ~i_inval & (count_e < 3'd4) & ~err_e &
                     (i_access | (count_e != 3'd0));
    end

    always_comb begin
        mstate_d = mstate_q;
        m_addr_d = m_addr_q;
        case (mstate_q)
            MIdle: begin
                if (issue) begin
                    mstate_d = MFetch;
                    m_addr_d = next_fetch;
                end
            end
            MFetch: begin
                if (m_done) begin
                    mstate_d = MIdle;
                end else if (flush) begin
                    mstate_d = MDiscard;
                end
            end
            MDiscard: begin
                if (m_done) begin
                    mstate_d = MIdle;
                end
            end
            default: mstate_d = MIdle;
        endcase
    end

    always_comb begin
        count_d  = count_q;
        head_d   = head_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            count_d = 3'd0;
            if (miss) begin
                head_d = i_addr;
            end
        end else begin
            count_d = count_q + 3'(push) - 3'(hit);
            if (hit) begin
                head_d   = head_q + 30'd1;
                rd_ptr_d = rd_ptr_q + 2'd1;
            end
        end
    end

    always_comb begin
        i_ack_d   = hit;
        i_data_d  = hit ? data_q[rd_ptr_q] : 32'd0;
        i_error_d = hit & err_q[rd_ptr_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstate_q  <= MIdle;
            m_addr_q  <= 30'd0;
            count_q   <= 3'd0;
            head_q    <= 30'd0;
            rd_ptr_q  <= 2'd0;
            err_q     <= 4'd0;
            i_ack_q   <= 1'b0;
            i_error_q <= 1'b0;
            i_data_q  <= 32'd0;
        end else begin
            mstate_q  <= mstate_d;
            m_addr_q  <= m_addr_d;
            count_q   <= count_d;
            head_q    <= head_d;
            rd_ptr_q  <= rd_ptr_d;
            i_ack_q   <= i_ack_d;
            i_error_q <= i_error_d;
            i_data_q  <= i_data_d;
            if (push) begin
                err_q[wr_idx] <= m_error;
            end
        end
    end

    // Payload storage needs no reset; occupancy alone says which slots are live.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_idx] <= m_data;
        end
    end

    assign m_access = (mstate_q != MIdle);
    assign m_addr   = m_addr_q;
    assign i_ack    = i_ack_q;
    assign i_error  = i_error_q;
    assign i_data   = i_data_q;

endmodule
